// File: rtl/ray_inv_scheduler.sv
// Shares one reciprocal divider across the x/y/z components of incoming ray directions and
// reassembles the reciprocals into a credit-protected output FIFO. Vectors pack as {x, y, z}, x in the MSBs.
module ray_inv_scheduler #(
  parameter int DIV_LATENCY = 41,
  parameter int RAY_ID_W    = 8,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*18-1:0]     in_dir,
  input  logic [RAY_ID_W-1:0] in_id,
  output logic [17:0]         div_divisor,
  output logic                div_valid,
  input  logic [35:0]         div_result,
  input  logic                div_by_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3*36-1:0]     out_inv,
  output logic [RAY_ID_W-1:0] out_id,
  output logic [2:0]          out_dbz,
  output logic                busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int ENT_W = 3*36 + RAY_ID_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_X, S_Y, S_Z} state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                div_valid_q, div_valid_d;
  logic [17:0]         div_divisor_q, div_divisor_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W:0]      credit_sum;
  logic                credit_ok;
  logic                accept, push, pop;

  logic [3*18-1:0]     dir_q;
  logic [RAY_ID_W-1:0] id_q;
  logic [1:0]          issue_comp;

  logic [DIV_LATENCY-1:0] sh_vld_q;
  logic [1:0]             sh_comp_q [DIV_LATENCY];
  logic [RAY_ID_W-1:0]    sh_id_q   [DIV_LATENCY];

  logic signed [35:0]  x_res_q, y_res_q;
  logic [1:0]          dbz_xy_q;
  logic [ENT_W-1:0]    fifo_mem [OUT_DEPTH];
  logic [ENT_W-1:0]    head;

  assign accept      = in_valid && in_ready_q;
  assign out_valid   = (fifo_cnt_q != '0);
  assign pop         = out_valid && out_ready;
  assign push        = sh_vld_q[DIV_LATENCY-1] && (sh_comp_q[DIV_LATENCY-1] == 2'd2);
  assign in_ready    = in_ready_q;
  assign div_valid   = div_valid_q;
  assign div_divisor = div_divisor_q;
  assign busy        = (state_q != S_IDLE) || (inflight_q != '0) || (fifo_cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      div_valid_q   <= 1'b0;
      div_divisor_q <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      div_valid_q   <= div_valid_d;
      div_divisor_q <= div_divisor_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_X;
      S_X:     state_d = S_Y;
      S_Y:     state_d = S_Z;
      S_Z:     state_d = accept ? S_X : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decided from the next state so the registered divider port and in_ready line up with it.
  always_comb begin : fsm_outputs
    div_valid_d   = 1'b0;
    div_divisor_d = '0;
    case (state_d)
      S_X: begin div_valid_d = 1'b1; div_divisor_d = in_dir[53:36]; end
      S_Y: begin div_valid_d = 1'b1; div_divisor_d = dir_q[35:18];  end
      S_Z: begin div_valid_d = 1'b1; div_divisor_d = dir_q[17:0];   end
      default: ;
    endcase
    in_ready_d = ((state_d == S_IDLE) || (state_d == S_Z)) && credit_ok;
  end

  always_comb begin : counters
    inflight_d = inflight_q;
    if (accept && !push)      inflight_d = inflight_q + 1'b1;
    else if (!accept && push) inflight_d = inflight_q - 1'b1;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)         fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop)    fifo_cnt_d = fifo_cnt_q - 1'b1;
    credit_sum = {1'b0, inflight_d} + {1'b0, fifo_cnt_d};
    credit_ok  = credit_sum < (CNT_W+1)'(OUT_DEPTH);
  end

  always_comb begin : comp_of_state
    case (state_q)
      S_Y:     issue_comp = 2'd1;
      S_Z:     issue_comp = 2'd2;
      default: issue_comp = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_reg
    if (!rst_n) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sh_vld_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      sh_vld_q   <= {sh_vld_q[DIV_LATENCY-2:0], div_valid_q};
    end
  end

  // Shadow tags travel beside the divider pipeline; only their valids need reset.
  always_ff @(posedge clk) begin : data_reg
    if (accept) begin
      dir_q <= in_dir;
      id_q  <= in_id;
    end
    sh_comp_q[0] <= issue_comp;
    sh_id_q[0]   <= id_q;
    for (int i = 1; i < DIV_LATENCY; i++) begin
      sh_comp_q[i] <= sh_comp_q[i-1];
      sh_id_q[i]   <= sh_id_q[i-1];
    end
    if (sh_vld_q[DIV_LATENCY-1]) begin
      if (sh_comp_q[DIV_LATENCY-1] == 2'd0) begin
        x_res_q     <= div_result;
        dbz_xy_q[0] <= div_by_zero;
      end
      if (sh_comp_q[DIV_LATENCY-1] == 2'd1) begin
        y_res_q     <= div_result;
        dbz_xy_q[1] <= div_by_zero;
      end
    end
    if (push)
      fifo_mem[wr_ptr_q] <= {x_res_q, y_res_q, div_result, sh_id_q[DIV_LATENCY-1],
                             div_by_zero, dbz_xy_q};
  end

  always_comb begin : fifo_head
    head    = fifo_mem[rd_ptr_q];
    out_inv = '0;
    out_id  = '0;
    out_dbz = '0;
    if (out_valid) begin
      out_inv = head[ENT_W-1 -: 3*36];
      out_id  = head[RAY_ID_W+2 : 3];
      out_dbz = head[2:0];
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_cnt_q == CNT_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_ray_inv_scheduler.sv
// Scoreboard bench for ray_inv_scheduler with a fixed-latency reciprocal divider model.
`timescale 1ns/1ps
module tb_ray_inv_scheduler;
  localparam int DL = 41;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, div_valid, div_by_zero, out_valid, busy;
  logic [53:0]  in_dir = '0;
  logic [7:0]   in_id = '0, out_id;
  logic [17:0]  div_divisor;
  logic [35:0]  div_result;
  logic [107:0] out_inv;
  logic [2:0]   out_dbz;

  ray_inv_scheduler #(.DIV_LATENCY(DL), .RAY_ID_W(8), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
    .in_id(in_id), .div_divisor(div_divisor), .div_valid(div_valid), .div_result(div_result),
    .div_by_zero(div_by_zero), .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
    .out_id(out_id), .out_dbz(out_dbz), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: 2^34 / d (1.0 in Q2.16 over Q2.16 gives Q18.18); zero divisor saturates with the flag set.
  function automatic logic [36:0] fdiv(input logic [17:0] d);
    longint q;
    if (d == '0) return {1'b1, 36'h7_FFFF_FFFF};
    q = 64'sd17179869184 / longint'($signed(d));
    return {1'b0, q[35:0]};
  endfunction

  logic [36:0] dpipe [DL];
  always @(posedge clk) begin
    dpipe[0] <= div_valid ? fdiv(div_divisor) : 37'h0_1234_5678;
    for (int i = 1; i < DL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_result  = dpipe[DL-1][35:0];
  assign div_by_zero = dpipe[DL-1][36];

  typedef struct packed { logic [53:0] dir; logic [107:0] inv; logic [2:0] dbz; } vec_t;
  typedef struct packed { logic [107:0] inv; logic [7:0] id; logic [2:0] dbz; } exp_t;

  vec_t tbl [5];
  exp_t exp_q [$];
  int   acc_cyc_q [$];
  int   pop_cyc_q [$];
  int   checks = 0, failures = 0, accepts = 0, stream_left = 0, cur_t = 0;
  bit   rot = 1'b0;
  logic [7:0] next_id = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual_id=%0h required=none", out_id);
      end else begin
        e = exp_q.pop_front();
        check("out_inv", out_inv, e.inv);
        check("out_id", out_id, e.id);
        check("out_dbz", out_dbz, e.dbz);
      end
    end
  end

  task automatic load_ray(input int t);
    cur_t    = t;
    in_dir   = tbl[t].dir;
    in_id    = next_id;
    in_valid = 1'b1;
  endtask

  task automatic step();
    logic acc;
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      e.inv = tbl[cur_t].inv; e.id = in_id; e.dbz = tbl[cur_t].dbz;
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc);
      accepts++;
    end
    @(posedge clk); #1;
    if (acc) begin
      stream_left--;
      next_id++;
      if (stream_left > 0) load_ray(rot ? (cur_t + 1) % 4 : cur_t);
      else in_valid = 1'b0;
    end
  endtask

  task automatic wait_accept(input int base);
    for (int i = 0; i < 200 && accepts == base; i++) step();
    check("accept_seen", accepts, base + 1);
  endtask

  task automatic measure_latency(input string name);
    int acc_c, lat;
    acc_c = acc_cyc_q[$];
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = cyc - acc_c; break; end
    end
    check(name, lat, 45);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (stream_left == 0 && exp_q.size() == 0 && !busy) begin done = 1'b1; break; end
      step();
    end
    check("drain_idle", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base, stale, a0, rel;
    tbl[0] = '{dir: {18'h10000, 18'h20000, 18'h08000},
               inv: {36'h0_0004_0000, 36'hF_FFFE_0000, 36'h0_0008_0000}, dbz: 3'b000};
    tbl[1] = '{dir: {18'h30000, 18'h04000, 18'h38000},
               inv: {36'hF_FFFC_0000, 36'h0_0010_0000, 36'hF_FFF8_0000}, dbz: 3'b000};
    tbl[2] = '{dir: {18'h08000, 18'h3C000, 18'h10000},
               inv: {36'h0_0008_0000, 36'hF_FFF0_0000, 36'h0_0004_0000}, dbz: 3'b000};
    tbl[3] = '{dir: {18'h02000, 18'h30000, 18'h04000},
               inv: {36'h0_0020_0000, 36'hF_FFFC_0000, 36'h0_0010_0000}, dbz: 3'b000};
    tbl[4] = '{dir: {18'h00000, 18'h10000, 18'h00000},
               inv: {36'h7_FFFF_FFFF, 36'h0_0004_0000, 36'h7_FFFF_FFFF}, dbz: 3'b101};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_div_valid", div_valid, 1'b0);
    check("rst_div_divisor", div_divisor, 18'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inv", out_inv, 108'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1'b1);
    out_ready = 1'b1;

    // Single ray (1.0, -2.0, 0.5) id 5, with divider issue order
    rot = 1'b0; next_id = 8'd5; stream_left = 1; load_ray(0);
    wait_accept(accepts);
    check("issue_x_valid", div_valid, 1'b1);
    check("issue_x", div_divisor, 18'h10000);
    @(posedge clk); #1 check("issue_y", div_divisor, 18'h20000);
    @(posedge clk); #1 check("issue_z", div_divisor, 18'h08000);
    @(posedge clk); #1 check("issue_idle", div_valid, 1'b0);
    measure_latency("latency_single");
    drain(100);

    // Ten rays streamed; the 4-ray credit splits them into bursts 46 cycles apart
    acc_cyc_q.delete(); pop_cyc_q.delete();
    rot = 1'b1; next_id = 8'h10; stream_left = 10; load_ray(0);
    drain(400);
    check("stream_accepts", acc_cyc_q.size(), 10);
    check("stream_pops", pop_cyc_q.size(), 10);
    if (acc_cyc_q.size() == 10 && pop_cyc_q.size() == 10)
      for (int k = 0; k < 10; k++) begin
        rel = (k / 4) * 46 + (k % 4) * 3;
        check($sformatf("accept_time_%0d", k), acc_cyc_q[k] - acc_cyc_q[0], rel);
        check($sformatf("pop_time_%0d", k), pop_cyc_q[k] - acc_cyc_q[0], rel + 45);
      end

    // Zero components
    rot = 1'b0; next_id = 8'h2A; stream_left = 1; load_ray(4);
    drain(200);

    // Backpressure: four credits, then a single pop frees exactly one
    out_ready = 1'b0;
    base = accepts;
    rot = 1'b1; next_id = 8'h40; stream_left = 6; load_ray(1);
    repeat (80) step();
    check("bp_accepts", accepts - base, 4);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_credit_next_cycle", in_ready, 1'b1);
    step();
    check("bp_one_more_accept", accepts - base, 5);
    repeat (5) step();
    check("bp_still_five", accepts - base, 5);
    out_ready = 1'b1;
    drain(300);

    // Reset with three rays in flight
    a0 = accepts;
    rot = 1'b1; next_id = 8'h60; stream_left = 3; load_ray(0);
    wait_accept(a0);
    for (int i = 0; i < 40 && cyc < acc_cyc_q[$] + 20; i++) step();
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_div_valid", div_valid, 1'b0);
    exp_q.delete(); stream_left = 0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_out", stale, 0);
    @(posedge clk); #1;
    rot = 1'b0; next_id = 8'h77; stream_left = 1; load_ray(2);
    wait_accept(accepts);
    measure_latency("latency_after_reset");
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
